// File: rtl/mpu_result_drain_if.sv
// mpu_result_drain_if: start/matrix inputs and row-stream handshake of the MPU result drain
interface mpu_result_drain_if #(
   parameter int N     = 8,
   parameter int ACC_W = 17
);
   logic                                start;
   logic [0:N-1][0:N-1][ACC_W-1:0]      c;
   logic                                row_valid;
   logic                                row_ready;
   logic [0:N-1][ACC_W-1:0]             out_row;
   logic [$clog2(N)-1:0]                row_idx;
   logic                                acc_clr;
   logic                                busy;
   logic                                done;
   modport master (
      input  start, c, row_ready,
      output row_valid, out_row, row_idx, acc_clr, busy, done
   );
   modport slave (
      output start, c, row_ready,
      input  row_valid, out_row, row_idx, acc_clr, busy, done
   );
endinterface

// File: rtl/mpu_result_drain.sv
// mpu_result_drain: snapshot the NxN accumulator matrix on start and stream it out one row per handshake; define MPU_DRAIN_SAT_EN to clamp output elements to SAT_MAX
module mpu_result_drain #(
   parameter int N       = 8,
   parameter int ACC_W   = 17,
   parameter int SAT_MAX = 255
) (
   input logic               clk,
   input logic               rst,
   mpu_result_drain_if.master bus
);
   localparam int IW = $clog2(N);
   localparam logic [ACC_W-1:0] CEIL = ACC_W'(SAT_MAX);
`ifdef MPU_DRAIN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif
   typedef enum logic {IDLE, SEND} state_t;
   state_t                         state;
   logic [0:N-1][0:N-1][ACC_W-1:0] snap;
   logic [IW-1:0]                  idx;
   logic                           done_q;
   logic                           clr_q;
   // capture on start, then advance one row per accepted handshake until the last row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         snap   <= '0;
         idx    <= '0;
         done_q <= 1'b0;
         clr_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         clr_q  <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               snap  <= bus.c;
               idx   <= '0;
               clr_q <= 1'b1;
               state <= SEND;
            end
         end else if (bus.row_ready) begin
            if (idx == IW'(N - 1)) begin
               idx    <= '0;
               done_q <= 1'b1;
               state  <= IDLE;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end
   // current snapshot row, optionally clamped; the snapshot itself keeps full width
   always_comb begin
      for (int k = 0; k < N; k++)
         bus.out_row[k] = (SAT_EN && snap[idx][k] > CEIL) ? CEIL : snap[idx][k];
   end
   assign bus.row_valid = (state == SEND);
   assign bus.busy      = (state == SEND);
   assign bus.row_idx   = idx;
   assign bus.done      = done_q;
   assign bus.acc_clr   = clr_q;
endmodule

// File: tb/tb_mpu_result_drain.sv
// tb_mpu_result_drain: directed and randomized checks of mpu_result_drain against a row-queue reference model
module tb_mpu_result_drain;
   localparam int N       = 8;
   localparam int ACC_W   = 17;
   localparam int SAT_MAX = 255;
   localparam int W       = N * ACC_W;
   typedef logic [0:N-1][ACC_W-1:0] row_t;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   mpu_result_drain_if #(.N(N), .ACC_W(ACC_W)) bus ();
   mpu_result_drain #(.N(N), .ACC_W(ACC_W), .SAT_MAX(SAT_MAX)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   row_t q[$];
   int   sent;
   logic done_e;
   logic clr_e;
   function automatic row_t sat(input row_t r);
      row_t o = r;
`ifdef MPU_DRAIN_SAT_EN
      for (int k = 0; k < N; k++) if (o[k] > ACC_W'(SAT_MAX)) o[k] = ACC_W'(SAT_MAX);
`endif
      return o;
   endfunction
   // reference: a queue of rows still owed downstream; empty queue means idle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         sent   = 0;
         done_e = 1'b0;
         clr_e  = 1'b0;
      end else begin
         done_e = 1'b0;
         clr_e  = 1'b0;
         if (q.size() != 0) begin
            if (bus.row_ready) begin
               void'(q.pop_front());
               sent++;
               if (q.size() == 0) begin
                  done_e = 1'b1;
                  sent   = 0;
               end
            end
         end else if (bus.start) begin
            for (int r = 0; r < N; r++) q.push_back(sat(bus.c[r]));
            clr_e = 1'b1;
         end
      end
   end
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic compare();
      logic v;
      v = (q.size() != 0);
      chk("row_valid", W'(bus.row_valid), W'(v));
      chk("busy", W'(bus.busy), W'(v));
      chk("row_idx", W'(bus.row_idx), W'(sent));
      chk("done", W'(bus.done), W'(done_e));
      chk("acc_clr", W'(bus.acc_clr), W'(clr_e));
      if (v) chk("out_row", W'(bus.out_row), W'(q[0]));
      else if (rst) chk("out_row_rst", W'(bus.out_row), '0);
   endtask
   task automatic step(input logic s, input logic rdy);
      bus.start     = s;
      bus.row_ready = rdy;
      @(negedge clk);
      compare();
   endtask
   task automatic rand_c();
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++)
            bus.c[r][k] = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 400));
   endtask
   task automatic drain();
      for (int i = 0; i < 4 * N && q.size() != 0; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("idle_after_drain", W'(bus.row_valid), '0);
   endtask
   initial begin
      row_t r5;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.row_ready = 1'b0;
      bus.c         = '0;
      @(negedge clk);
      compare();
      rst = 1'b0;
      // ramp matrix, full throughput
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) bus.c[r][k] = ACC_W'(16 * r + k);
      step(1'b1, 1'b1);
      chk("acc_clr_after_start", W'(bus.acc_clr), W'(1'b1));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      for (int k = 0; k < N; k++) r5[k] = ACC_W'(80 + k);
      chk("row5_value", W'(bus.out_row), W'(r5));
      chk("row5_idx", W'(bus.row_idx), W'(5));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      chk("done_after_last", W'(bus.done), W'(1'b1));
      step(1'b0, 1'b0);
      chk("done_one_cycle", W'(bus.done), '0);
      // backpressure on drain cycles 2-4
      rand_c();
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      chk("stall_idx", W'(bus.row_idx), W'(1));
      drain();
      // snapshot isolation
      rand_c();
      step(1'b1, 1'b1);
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) bus.c[r][k] = 17'h1FFFF;
      drain();
      // start during SEND, on last handshake, and in the done cycle
      rand_c();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      chk("last_row_idx", W'(bus.row_idx), W'(N - 1));
      step(1'b1, 1'b1);
      chk("done_ignored_start", W'(bus.done), W'(1'b1));
      chk("idle_in_done", W'(bus.row_valid), '0);
      rand_c();
      step(1'b1, 1'b1);
      chk("restart_valid", W'(bus.row_valid), W'(1'b1));
      drain();
      // saturation corner values
      rand_c();
      bus.c[0][0] = 17'd300;
      bus.c[0][1] = 17'd255;
      bus.c[0][2] = 17'h1FFFF;
      step(1'b1, 1'b0);
`ifdef MPU_DRAIN_SAT_EN
      chk("sat_300", W'(bus.out_row[0]), W'(255));
      chk("sat_255", W'(bus.out_row[1]), W'(255));
      chk("sat_max", W'(bus.out_row[2]), W'(255));
`else
      chk("sat_300", W'(bus.out_row[0]), W'(300));
      chk("sat_255", W'(bus.out_row[1]), W'(255));
      chk("sat_max", W'(bus.out_row[2]), W'(131071));
`endif
      drain();
      // asynchronous reset mid-drain at row 3
      rand_c();
      step(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      chk("pre_reset_idx", W'(bus.row_idx), W'(3));
      #2 rst = 1'b1;
      #1 compare();
      chk("reset_valid", W'(bus.row_valid), '0);
      @(negedge clk);
      compare();
      chk("reset_no_done", W'(bus.done), '0);
      rst = 1'b0;
      rand_c();
      step(1'b1, 1'b1);
      chk("restart_row0", W'(bus.row_idx), '0);
      drain();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) rand_c();
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
